jtexterm_palread: RTL and testbench

//  Colour-mixer read stage placed downstream of the X1-007 palette RAM. Picks the winning

---
 rtl/jtexterm_palread_if.sv | 32 +++
 rtl/jtexterm_palread.sv | 103 ++++++++++
 tb/tb_jtexterm_palread.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/jtexterm_palread_if.sv
// Pixel / palette / video bundle for the colour-mixer read stage.
//  master : pixel source, palette RAM read data and video consumer
//  slave  : jtexterm_palread itself
//  Pixel side : pxl_cen, LHBL, LVBL, obj_pxl, scr_pxl, gfx_en
//  RAM side   : pal_addr (out of slave), pal_dout (into slave)
//  Video side : red, green, blue, LHBL_dly, LVBL_dly, overrun
interface jtexterm_palread_if;
  logic       pxl_cen;
  logic       LHBL;
  logic       LVBL;
  logic [8:0] obj_pxl;
  logic [8:0] scr_pxl;
  logic [3:0] gfx_en;
  logic [9:0] pal_addr;
  logic [7:0] pal_dout;
  logic [4:0] red;
  logic [4:0] green;
  logic [4:0] blue;
  logic       LHBL_dly;
  logic       LVBL_dly;
  logic       overrun;

  modport master (
    output pxl_cen, LHBL, LVBL, obj_pxl, scr_pxl, gfx_en, pal_dout,
    input  pal_addr, red, green, blue, LHBL_dly, LVBL_dly, overrun
  );

  modport slave (
    input  pxl_cen, LHBL, LVBL, obj_pxl, scr_pxl, gfx_en, pal_dout,
    output pal_addr, red, green, blue, LHBL_dly, LVBL_dly, overrun
  );
endinterface

// File: rtl/jtexterm_palread.sv
// Colour-mixer read stage behind the X1-007 palette RAM.
// Selects the winning layer pixel (object over scroll), reads its two palette
// bytes (low at {idx,0}, high at {idx,1}), assembles xRRRRRGGGGGBBBBB and
// drives blanked 5-bit RGB one pixel period after the pixel was sampled.
//  clk, rst_n : video clock, asynchronous active-low reset
//  bus        : jtexterm_palread_if.slave (pixel inputs, palette RAM port,
//               RGB / delayed blanking / sticky overrun outputs)
//  BLANK_OFFSET : 1 keeps RGB at 0 for the first visible pixel after blanking
module jtexterm_palread #(
  parameter int unsigned BLANK_OFFSET = 0
) (
  input logic               clk,
  input logic               rst_n,
  jtexterm_palread_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ADDR_HI, CAP_LO, CAP_HI} state_t;

  state_t      r_state;
  logic [8:0]  r_idx;
  logic [7:0]  r_lo;
  logic [14:0] r_col;
  logic [14:0] r_rgb;
  logic [9:0]  r_pal_addr;
  logic        r_hb;
  logic        r_vb;
  logic        r_hb_dly;
  logic        r_vb_dly;
  logic        r_overrun;

  logic [8:0]  w_idx;
  logic        w_blank;
  logic        w_unused;

  always_comb begin
    w_idx = '0;
    if (bus.gfx_en[1] && (bus.obj_pxl[3:0] != 4'd0)) w_idx = bus.obj_pxl;
    else if (bus.gfx_en[0])                           w_idx = bus.scr_pxl;
  end

  // r_hb/r_vb become the new delayed blanking on this pxl_cen; r_*_dly still
  // hold the previous pixel's visibility for the offset rule.
  always_comb begin
    w_blank = !(r_hb && r_vb);
    if ((BLANK_OFFSET != 0) && !(r_hb_dly && r_vb_dly)) w_blank = 1'b1;
  end

  assign w_unused = ^{bus.gfx_en[3:2], bus.pal_dout[7]};

  // The fetch steps come first and pxl_cen assignments last, so a pixel
  // landing mid-fetch overrides address/state while a CAP_HI in the same clk
  // still commits r_col; the output stage reads r_col before that update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_idx      <= '0;
      r_lo       <= '0;
      r_col      <= '0;
      r_rgb      <= '0;
      r_pal_addr <= '0;
      r_hb       <= 1'b0;
      r_vb       <= 1'b0;
      r_hb_dly   <= 1'b0;
      r_vb_dly   <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      case (r_state)
        ADDR_HI: begin
          r_pal_addr <= {r_idx, 1'b1};
          r_state    <= CAP_LO;
        end
        CAP_LO: begin
          r_lo    <= bus.pal_dout;
          r_state <= CAP_HI;
        end
        CAP_HI: begin
          r_col   <= {bus.pal_dout[6:0], r_lo};
          r_state <= IDLE;
        end
        default: ;
      endcase

      if (bus.pxl_cen) begin
        if (r_state != IDLE) r_overrun <= 1'b1;
        r_idx      <= w_idx;
        r_pal_addr <= {w_idx, 1'b0};
        r_state    <= ADDR_HI;
        r_hb       <= bus.LHBL;
        r_vb       <= bus.LVBL;
        r_hb_dly   <= r_hb;
        r_vb_dly   <= r_vb;
        r_rgb      <= w_blank ? '0 : r_col;
      end
    end
  end

  assign bus.pal_addr = r_pal_addr;
  assign bus.red      = r_rgb[14:10];
  assign bus.green    = r_rgb[9:5];
  assign bus.blue     = r_rgb[4:0];
  assign bus.LHBL_dly = r_hb_dly;
  assign bus.LVBL_dly = r_vb_dly;
  assign bus.overrun  = r_overrun;
endmodule

// File: tb/tb_jtexterm_palread.sv
// Bench for jtexterm_palread: two instances (BLANK_OFFSET 0 and 1) share one
// pixel stream and one palette image; a pixel-level reference model predicts
// RGB, delayed blanking, overrun and the palette address sequence.
module tb_jtexterm_palread;
  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  jtexterm_palread_if bus0 ();
  jtexterm_palread_if bus1 ();

  jtexterm_palread #(.BLANK_OFFSET(0)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  jtexterm_palread #(.BLANK_OFFSET(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  logic [7:0] mem [1024];

  // Palette RAM: one-clk registered read, data usable the 2nd clk after the address.
  always @(posedge clk) begin
    bus0.pal_dout <= mem[bus0.pal_addr];
    bus1.pal_dout <= mem[bus1.pal_addr];
  end

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  // Reference model state, one update per pixel.
  logic [14:0] m_col;
  logic [8:0]  m_idx;
  int          m_gap;
  logic        m_busy;
  logic        m_hb, m_vb, m_hb_dly, m_vb_dly, m_ov;

  function automatic logic [14:0] pal_word(input logic [8:0] i);
    logic [7:0] lo, hi;
    lo = mem[{i, 1'b0}];
    hi = mem[{i, 1'b1}];
    return {hi[6:0], lo};
  endfunction

  task automatic drive(input logic cen, input logic [8:0] obj, input logic [8:0] scr,
                       input logic [3:0] en, input logic hb, input logic vb);
    bus0.pxl_cen = cen; bus0.obj_pxl = obj; bus0.scr_pxl = scr;
    bus0.gfx_en  = en;  bus0.LHBL    = hb;  bus0.LVBL    = vb;
    bus1.pxl_cen = cen; bus1.obj_pxl = obj; bus1.scr_pxl = scr;
    bus1.gfx_en  = en;  bus1.LHBL    = hb;  bus1.LVBL    = vb;
  endtask

  task automatic scramble();
    drive(1'b0, 9'($urandom), 9'($urandom), 4'($urandom), 1'($urandom), 1'($urandom));
  endtask

  task automatic model_reset();
    m_col = '0; m_idx = '0; m_gap = 0; m_busy = 1'b0;
    m_hb = 1'b0; m_vb = 1'b0; m_hb_dly = 1'b0; m_vb_dly = 1'b0; m_ov = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_addr",  32'(bus0.pal_addr), 32'd0);
    chk("rst_rgb",   32'({bus0.red, bus0.green, bus0.blue}), 32'd0);
    chk("rst_rgb1",  32'({bus1.red, bus1.green, bus1.blue}), 32'd0);
    chk("rst_hdly",  32'(bus0.LHBL_dly), 32'd0);
    chk("rst_vdly",  32'(bus0.LVBL_dly), 32'd0);
    chk("rst_ovr",   32'(bus0.overrun), 32'd0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Called on a negedge; issues one pixel and waits 'gap' clocks until the next.
  task automatic do_pixel(input int gap, input logic [8:0] obj, input logic [8:0] scr,
                          input logic [3:0] en, input logic hb, input logic vb);
    logic [8:0]  sel;
    logic        vis;
    logic [14:0] e0, e1;
    sel = (en[1] && obj[3:0] != 4'd0) ? obj : (en[0] ? scr : 9'd0);
    // Previous fetch: done before this pixel if it had 4+ clks, lost if fewer.
    if (m_busy) begin
      if (m_gap >= 4) m_col = pal_word(m_idx);
      else            m_ov  = 1'b1;
    end
    vis = m_hb & m_vb;
    e0  = vis ? m_col : '0;
    e1  = (vis && m_hb_dly && m_vb_dly) ? m_col : '0;
    // A 3-clk gap finishes the fetch on this very pixel, too late for its output.
    if (m_busy && m_gap == 3) m_col = pal_word(m_idx);
    m_hb_dly = m_hb; m_vb_dly = m_vb; m_hb = hb; m_vb = vb;
    m_idx = sel; m_gap = gap; m_busy = 1'b1;

    drive(1'b1, obj, scr, en, hb, vb);
    @(negedge clk);
    scramble();
    chk("rgb",      32'({bus0.red, bus0.green, bus0.blue}), 32'(e0));
    chk("rgb_ofs",  32'({bus1.red, bus1.green, bus1.blue}), 32'(e1));
    chk("lhbl_dly", 32'(bus0.LHBL_dly), 32'(m_hb_dly));
    chk("lvbl_dly", 32'(bus0.LVBL_dly), 32'(m_vb_dly));
    chk("overrun",  32'(bus0.overrun), 32'(m_ov));
    chk("addr_lo",  32'(bus0.pal_addr), 32'({sel, 1'b0}));
    @(negedge clk);
    chk("addr_hi",  32'(bus0.pal_addr), 32'({sel, 1'b1}));
    for (int i = 2; i < gap; i++) begin
      scramble();
      @(negedge clk);
    end
    if (gap >= 4) chk("addr_hold", 32'(bus0.pal_addr), 32'({sel, 1'b1}));
  endtask

  task automatic rand_pixel(input int gap);
    logic [8:0] obj;
    obj = 9'($urandom);
    if ($urandom_range(0, 3) == 0) obj[3:0] = 4'd0;
    do_pixel(gap, obj, 9'($urandom), 4'($urandom),
             $urandom_range(0, 7) != 0, $urandom_range(0, 15) != 0);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom);
    mem[10'h0A0] = 8'h1F;
    mem[10'h0A1] = 8'h7C;
    mem[10'h246] = 8'h55;
    mem[10'h247] = 8'hAA;
    model_reset();
    drive(1'b0, '0, '0, '0, 1'b0, 1'b0);
    #2;
    do_reset();

    // Scroll pixel 0x050 -> 0x7C1F
    do_pixel(4, 9'h000, 9'h050, 4'h1, 1'b1, 1'b1);
    do_pixel(4, 9'h000, 9'h050, 4'h1, 1'b1, 1'b1);
    chk("t1_red",   32'(bus0.red),   32'd31);
    chk("t1_green", 32'(bus0.green), 32'd0);
    chk("t1_blue",  32'(bus0.blue),  32'd31);

    // Object priority, transparent object, both layers disabled
    do_pixel(4, 9'h123, 9'h050, 4'h3, 1'b1, 1'b1);
    do_pixel(4, 9'h120, 9'h050, 4'h3, 1'b1, 1'b1);
    do_pixel(4, 9'h1FF, 9'h1FF, 4'h0, 1'b1, 1'b1);
    do_pixel(4, 9'h1FF, 9'h1FF, 4'h0, 1'b0, 1'b1);
    do_pixel(4, 9'h123, 9'h050, 4'h2, 1'b1, 1'b1);
    do_pixel(4, 9'h123, 9'h050, 4'h2, 1'b1, 1'b1);

    for (int n = 0; n < 150; n++) rand_pixel(4 + $urandom_range(0, 2));

    // Pixel period too short
    for (int n = 0; n < 5; n++) do_pixel(3, 9'h123, 9'h050, 4'h2, 1'b1, 1'b1);
    chk("ovr_set", 32'(bus0.overrun), 32'd1);
    for (int n = 0; n < 25; n++) rand_pixel($urandom_range(2, 4));
    for (int n = 0; n < 60; n++) rand_pixel(4 + $urandom_range(0, 2));
    chk("ovr_sticky", 32'(bus0.overrun), 32'd1);

    // Reset just before c2 of a fetch
    do_pixel(2, 9'h123, 9'h050, 4'h2, 1'b1, 1'b1);
    do_reset();
    do_pixel(4, 9'h123, 9'h050, 4'h2, 1'b1, 1'b1);
    do_pixel(4, 9'h123, 9'h050, 4'h2, 1'b1, 1'b1);
    chk("rst_resume", 32'({bus0.red, bus0.green, bus0.blue}), 32'h2A55);
    for (int n = 0; n < 40; n++) rand_pixel(4 + $urandom_range(0, 2));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
